fft_out_reorder: RTL and testbench

Output-side reorder buffer for the parallel FFT datapath. It accepts 16-lane I/Q vectors in bit-reversed frequency order, as produced by the last butterfly/delay-line stage. It emits the same frame in natural order, 16 consecutive bins per cycle. It is a ping-pong buffer: one bank fills with the incoming frame while the other drains the previous frame.

---
 rtl/fft_out_reorder.sv | 169 ++++++++++++++++
 tb/tb_fft_out_reorder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: takes 16-lane vectors in bit-reversed bin order and
// emits each frame in natural order, one vector per cycle, with registered outputs.
module fft_out_reorder #(
   parameter int unsigned DATA_WIDTH = 9,
   parameter int unsigned NUM_LANE   = 16,
   parameter int unsigned NUM_VEC    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din_valid,
   input  logic                  din_sof,
   input  logic [DATA_WIDTH-1:0] din_i [0:NUM_LANE-1],
   input  logic [DATA_WIDTH-1:0] din_q [0:NUM_LANE-1],
   output logic                  dout_valid,
   output logic                  dout_sof,
   output logic                  dout_last,
   output logic [DATA_WIDTH-1:0] dout_i [0:NUM_LANE-1],
   output logic [DATA_WIDTH-1:0] dout_q [0:NUM_LANE-1],
   output logic                  frame_err
);

   localparam int unsigned N  = NUM_LANE * NUM_VEC;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned LW = $clog2(NUM_LANE);
   localparam int unsigned VW = $clog2(NUM_VEC);
   localparam int unsigned SW = 2 * DATA_WIDTH;
   localparam logic [VW-1:0] LastVec = VW'(NUM_VEC - 1);

   typedef enum logic {StIdle, StRead} state_e;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int b = 0; b < AW; b++) begin
         r[b] = a[AW-1-b];
      end
      return r;
   endfunction

   state_e          state_q, state_d;
   logic [VW-1:0]   wc_q, wc_d;
   logic [VW-1:0]   rc_q, rc_d;
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic            dout_valid_q, dout_valid_d;
   logic            dout_sof_q, dout_sof_d;
   logic            dout_last_q, dout_last_d;
   logic            frame_err_q, frame_err_d;
   logic [DATA_WIDTH-1:0] dout_i_q [0:NUM_LANE-1];
   logic [DATA_WIDTH-1:0] dout_i_d [0:NUM_LANE-1];
   logic [DATA_WIDTH-1:0] dout_q_q [0:NUM_LANE-1];
   logic [DATA_WIDTH-1:0] dout_q_d [0:NUM_LANE-1];

   // Both banks in one array; the top address bit selects the bank.
   logic [SW-1:0]   mem_q [0:2*N-1];
   logic            wr_en;
   logic            frame_done;
   logic [VW-1:0]   wr_vec;
   logic [AW:0]     wr_addr [0:NUM_LANE-1];
   logic [SW-1:0]   rd_word [0:NUM_LANE-1];

   always_comb begin
      wr_en       = din_valid;
      wr_vec      = din_sof ? '0 : wc_q;
      wc_d        = wc_q;
      wr_bank_d   = wr_bank_q;
      frame_done  = 1'b0;
      frame_err_d = 1'b0;
      if (din_valid) begin
         frame_err_d = din_sof && (wc_q != '0);
         if (wr_vec == LastVec) begin
            wc_d       = '0;
            wr_bank_d  = ~wr_bank_q;
            frame_done = 1'b1;
         end else begin
            wc_d = wr_vec + 1'b1;
         end
      end
      for (int l = 0; l < NUM_LANE; l++) begin
         wr_addr[l] = {wr_bank_q, bitrev({wr_vec, LW'(l)})};
         rd_word[l] = mem_q[{rd_bank_q, rc_q, LW'(l)}];
      end
   end

   always_comb begin
      state_d      = state_q;
      rc_d         = rc_q;
      rd_bank_d    = rd_bank_q;
      dout_valid_d = 1'b0;
      dout_sof_d   = 1'b0;
      dout_last_d  = 1'b0;
      for (int l = 0; l < NUM_LANE; l++) begin
         dout_i_d[l] = '0;
         dout_q_d[l] = '0;
      end
      unique case (state_q)
         StIdle: ;
         StRead: begin
            dout_valid_d = 1'b1;
            dout_sof_d   = (rc_q == '0);
            dout_last_d  = (rc_q == LastVec);
            for (int l = 0; l < NUM_LANE; l++) begin
               dout_i_d[l] = rd_word[l][SW-1:DATA_WIDTH];
               dout_q_d[l] = rd_word[l][DATA_WIDTH-1:0];
            end
            if (rc_q == LastVec) begin
               state_d = StIdle;
               rc_d    = '0;
            end else begin
               rc_d = rc_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      // A completing frame always wins; it can only coincide with the last read vector.
      if (frame_done) begin
         state_d   = StRead;
         rc_d      = '0;
         rd_bank_d = wr_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int l = 0; l < NUM_LANE; l++) begin
            mem_q[wr_addr[l]] <= {din_i[l], din_q[l]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         wc_q         <= '0;
         rc_q         <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_sof_q   <= 1'b0;
         dout_last_q  <= 1'b0;
         frame_err_q  <= 1'b0;
         for (int l = 0; l < NUM_LANE; l++) begin
            dout_i_q[l] <= '0;
            dout_q_q[l] <= '0;
         end
      end else begin
         state_q      <= state_d;
         wc_q         <= wc_d;
         rc_q         <= rc_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         dout_valid_q <= dout_valid_d;
         dout_sof_q   <= dout_sof_d;
         dout_last_q  <= dout_last_d;
         frame_err_q  <= frame_err_d;
         for (int l = 0; l < NUM_LANE; l++) begin
            dout_i_q[l] <= dout_i_d[l];
            dout_q_q[l] <= dout_q_d[l];
         end
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout_sof   = dout_sof_q;
   assign dout_last  = dout_last_q;
   assign frame_err  = frame_err_q;
   assign dout_i     = dout_i_q;
   assign dout_q     = dout_q_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: table of frame scenarios plus abort and
// mid-read reset sequences, checked by an output monitor against a reference model.
module tb_fft_out_reorder;

   localparam int DW = 9;
   localparam int NL = 16;
   localparam int NV = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          din_valid = 1'b0;
   logic          din_sof = 1'b0;
   logic [DW-1:0] din_i [0:NL-1];
   logic [DW-1:0] din_q [0:NL-1];
   logic          dout_valid, dout_sof, dout_last, frame_err;
   logic [DW-1:0] dout_i [0:NL-1];
   logic [DW-1:0] dout_q [0:NL-1];

   fft_out_reorder #(.DATA_WIDTH(DW), .NUM_LANE(NL), .NUM_VEC(NV)) dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_sof    (din_sof),
      .din_i      (din_i),
      .din_q      (din_q),
      .dout_valid (dout_valid),
      .dout_sof   (dout_sof),
      .dout_last  (dout_last),
      .dout_i     (dout_i),
      .dout_q     (dout_q),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int off;
      bit ext;
      int sof_cyc;
   } desc_t;

   typedef struct {
      int off;
      bit ext;
      int gap;
      int nfr;
      int exp_run;
   } case_t;

   desc_t exp_q[$];
   desc_t cur;
   bit    have_cur = 1'b0;
   int    n_checks = 0;
   int    n_fail = 0;
   int    k = 0;
   int    run = 0;
   int    last_run = 0;
   int    err_hi = 0;
   int    err_pulses = 0;
   int    err_cyc = -1;
   bit    err_prev = 1'b0;

   task automatic chk(input string name, input bit ok, input int act, input int expv);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int bitrev9(input int a);
      int r = 0;
      for (int b = 0; b < 9; b++) begin
         if (a[b]) r = r | (1 << (8 - b));
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] val_i(input int off, input bit ext, input int bin);
      if (ext) return bin[0] ? 9'h100 : 9'h0FF;
      return DW'(bin + off);
   endfunction

   function automatic logic [DW-1:0] val_q(input int off, input bit ext, input int bin);
      if (ext) return bin[0] ? 9'h0FF : 9'h100;
      return DW'(-(bin + off));
   endfunction

   task automatic idle(input int n);
      din_valid = 1'b0;
      din_sof   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int off, input bit ext, input int gap, input bit use_sof,
                             input int nvec, input bit push);
      desc_t d;
      int    bin;
      for (int c = 0; c < nvec; c++) begin
         din_valid = 1'b1;
         din_sof   = use_sof && (c == 0);
         for (int l = 0; l < NL; l++) begin
            bin      = bitrev9(16 * c + l);
            din_i[l] = val_i(off, ext, bin);
            din_q[l] = val_q(off, ext, bin);
         end
         if (push && c == nvec - 1) begin
            d.off     = off;
            d.ext     = ext;
            d.sof_cyc = cyc + 2;
            exp_q.push_back(d);
         end
         @(posedge clk);
         #1;
         if (c != nvec - 1) begin
            for (int g = 0; g < gap; g++) begin
               din_valid = 1'b0;
               din_sof   = 1'b0;
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   // Output monitor: contiguity, flags, latency and data against the expected-frame queue.
   initial begin
      bit ok;
      int bad_a, bad_e;
      logic [DW-1:0] ei, eq;
      forever begin
         @(negedge clk);
         if (rst) begin
            k = 0;
            run = 0;
            have_cur = 1'b0;
            exp_q.delete();
         end else begin
            if (frame_err) err_hi++;
            if (frame_err && !err_prev) begin
               err_pulses++;
               err_cyc = cyc;
            end
            err_prev = frame_err;
            if (dout_valid) begin
               run++;
               if (k == 0) begin
                  if (exp_q.size() == 0) begin
                     have_cur = 1'b0;
                     chk("unexpected_output", 1'b0, cyc, -1);
                  end else begin
                     cur = exp_q.pop_front();
                     have_cur = 1'b1;
                     chk("sof_latency", cyc == cur.sof_cyc, cyc, cur.sof_cyc);
                  end
               end
               chk("sof_flag", dout_sof == (k == 0), int'(dout_sof), int'(k == 0));
               chk("last_flag", dout_last == (k == NV - 1), int'(dout_last), int'(k == NV - 1));
               if (have_cur) begin
                  ok = 1'b1;
                  bad_a = 0;
                  bad_e = 0;
                  for (int l = 0; l < NL; l++) begin
                     ei = val_i(cur.off, cur.ext, 16 * k + l);
                     eq = val_q(cur.off, cur.ext, 16 * k + l);
                     if (ok && (dout_i[l] !== ei || dout_q[l] !== eq)) begin
                        ok = 1'b0;
                        bad_a = {dout_i[l], dout_q[l]};
                        bad_e = {ei, eq};
                     end
                  end
                  chk("data_iq", ok, bad_a, bad_e);
               end
               k = (k == NV - 1) ? 0 : k + 1;
            end else begin
               if (run > 0) last_run = run;
               run = 0;
               ok = !dout_sof && !dout_last;
               for (int l = 0; l < NL; l++) begin
                  if (dout_i[l] != '0 || dout_q[l] != '0) ok = 1'b0;
               end
               chk("idle_outputs_zero", ok, int'(ok), 1);
               chk("output_contiguous", k == 0, k, 0);
            end
         end
      end
   end

   initial begin
      case_t tbl[4];
      bit    ok;
      int    tgt, vcnt, d_cyc, base;

      tbl[0] = '{off: 0,   ext: 1'b0, gap: 0, nfr: 1, exp_run: 32};
      tbl[1] = '{off: 100, ext: 1'b0, gap: 0, nfr: 3, exp_run: 96};
      tbl[2] = '{off: 300, ext: 1'b0, gap: 2, nfr: 1, exp_run: 32};
      tbl[3] = '{off: 0,   ext: 1'b1, gap: 0, nfr: 1, exp_run: 32};

      for (int l = 0; l < NL; l++) begin
         din_i[l] = '0;
         din_q[l] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      ok = !dout_valid && !dout_sof && !dout_last && !frame_err;
      for (int l = 0; l < NL; l++) if (dout_i[l] != '0 || dout_q[l] != '0) ok = 1'b0;
      chk("reset_outputs", ok, int'(ok), 1);
      rst = 1'b0;
      idle(3);

      for (int t = 0; t < 4; t++) begin
         last_run = 0;
         for (int f = 0; f < tbl[t].nfr; f++) begin
            send_frame(tbl[t].off + 37 * f, tbl[t].ext, tbl[t].gap, 1'b1, NV, 1'b1);
         end
         idle(40);
         chk("frames_drained", exp_q.size() == 0, exp_q.size(), 0);
         chk("valid_run_length", last_run == tbl[t].exp_run, last_run, tbl[t].exp_run);
      end

      // Abort: 10 vectors then a fresh sof-marked frame.
      base = err_pulses;
      send_frame(5, 1'b0, 0, 1'b1, 10, 1'b0);
      d_cyc = cyc;
      send_frame(77, 1'b0, 0, 1'b1, NV, 1'b1);
      idle(40);
      chk("abort_err_pulses", err_pulses - base == 1, err_pulses - base, 1);
      chk("abort_err_timing", err_cyc == d_cyc + 1 || err_cyc == d_cyc + 2, err_cyc, d_cyc + 1);
      chk("abort_frames_drained", exp_q.size() == 0, exp_q.size(), 0);

      // Reset while output vector 5 is on the bus.
      send_frame(11, 1'b0, 0, 1'b1, NV, 1'b1);
      din_valid = 1'b0;
      din_sof   = 1'b0;
      tgt = exp_q[exp_q.size() - 1].sof_cyc + 5;
      while (cyc < tgt) begin
         @(posedge clk);
         #1;
      end
      chk("pre_reset_valid", dout_valid == 1'b1, int'(dout_valid), 1);
      rst = 1'b1;
      #1;
      ok = !dout_valid && !dout_sof && !dout_last;
      for (int l = 0; l < NL; l++) if (dout_i[l] != '0 || dout_q[l] != '0) ok = 1'b0;
      chk("async_reset_clears", ok, int'(ok), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (dout_valid) vcnt++;
      end
      chk("no_output_after_reset", vcnt == 0, vcnt, 0);
      send_frame(200, 1'b0, 0, 1'b1, NV, 1'b1);
      idle(40);
      chk("post_reset_frame_drained", exp_q.size() == 0, exp_q.size(), 0);

      chk("frame_err_total_pulses", err_pulses == 1, err_pulses, 1);
      chk("frame_err_width", err_hi == 1, err_hi, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
